// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: requester-side and controller-side signals around the sdram arbiter
interface sdram_arbiter_if;
  logic p0_req, p0_gnt, p0_sdrc_cmd_en, p0_sdrc_precharge_ctrl, p0_sdrc_cmd_ack, p0_sdrc_init_done;
  logic [2:0] p0_sdrc_cmd;
  logic [20:0] p0_sdrc_addr;
  logic [3:0] p0_sdrc_dqm;
  logic [31:0] p0_sdrc_data, p0_sdrc_rdata;
  logic [7:0] p0_sdrc_data_len;
  logic p1_req, p1_gnt, p1_sdrc_cmd_en, p1_sdrc_precharge_ctrl, p1_sdrc_cmd_ack, p1_sdrc_init_done;
  logic [2:0] p1_sdrc_cmd;
  logic [20:0] p1_sdrc_addr;
  logic [3:0] p1_sdrc_dqm;
  logic [31:0] p1_sdrc_data, p1_sdrc_rdata;
  logic [7:0] p1_sdrc_data_len;
  logic I_sdrc_cmd_en, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh;
  logic [2:0] I_sdrc_cmd;
  logic [20:0] I_sdrc_addr;
  logic [3:0] I_sdrc_dqm;
  logic [31:0] I_sdrc_data;
  logic [7:0] I_sdrc_data_len;
  logic [31:0] O_sdrc_data;
  logic O_sdrc_cmd_ack, O_sdrc_init_done;
  modport slave (
    input p0_req, p0_sdrc_cmd_en, p0_sdrc_cmd, p0_sdrc_precharge_ctrl, p0_sdrc_addr, p0_sdrc_dqm,
    input p0_sdrc_data, p0_sdrc_data_len,
    input p1_req, p1_sdrc_cmd_en, p1_sdrc_cmd, p1_sdrc_precharge_ctrl, p1_sdrc_addr, p1_sdrc_dqm,
    input p1_sdrc_data, p1_sdrc_data_len,
    input O_sdrc_data, O_sdrc_cmd_ack, O_sdrc_init_done,
    output p0_gnt, p0_sdrc_rdata, p0_sdrc_cmd_ack, p0_sdrc_init_done,
    output p1_gnt, p1_sdrc_rdata, p1_sdrc_cmd_ack, p1_sdrc_init_done,
    output I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
    output I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len
  );
  modport master (
    output p0_req, p0_sdrc_cmd_en, p0_sdrc_cmd, p0_sdrc_precharge_ctrl, p0_sdrc_addr, p0_sdrc_dqm,
    output p0_sdrc_data, p0_sdrc_data_len,
    output p1_req, p1_sdrc_cmd_en, p1_sdrc_cmd, p1_sdrc_precharge_ctrl, p1_sdrc_addr, p1_sdrc_dqm,
    output p1_sdrc_data, p1_sdrc_data_len,
    output O_sdrc_data, O_sdrc_cmd_ack, O_sdrc_init_done,
    input p0_gnt, p0_sdrc_rdata, p0_sdrc_cmd_ack, p0_sdrc_init_done,
    input p1_gnt, p1_sdrc_rdata, p1_sdrc_cmd_ack, p1_sdrc_init_done,
    input I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdram_power_down, I_sdram_selfrefresh,
    input I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port round-robin arbiter for one SDRAM controller with periodic auto-refresh
module sdram_arbiter #(
  parameter int RefreshIntervalCycles = 750,
  parameter logic [2:0] CmdAutoRefresh = 3'b001
) (
  input logic clk,
  input logic rst_n,
  sdram_arbiter_if.slave bus
);
  localparam int CW = RefreshIntervalCycles > 1 ? $clog2(RefreshIntervalCycles) : 1;
  typedef enum logic [2:0] {INIT, IDLE, GRANT0, GRANT1, REFRESH, REFRESH_WAIT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic pending, last_grant, expire, g0, g1, rf;
  assign expire = state != INIT && cnt == CW'(RefreshIntervalCycles - 1);
  assign g0 = state == GRANT0;
  assign g1 = state == GRANT1;
  assign rf = state == REFRESH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      pending <= 1'b0;
      last_grant <= 1'b1;
      bus.p0_gnt <= 1'b0;
      bus.p1_gnt <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= (state == INIT || expire) ? '0 : cnt + 1'b1;
      pending <= expire | (pending & ~(state == REFRESH_WAIT & bus.O_sdrc_cmd_ack));
      if (g0 && !bus.p0_req) last_grant <= 1'b0;
      else if (g1 && !bus.p1_req) last_grant <= 1'b1;
      bus.p0_gnt <= state_nxt == GRANT0;
      bus.p1_gnt <= state_nxt == GRANT1;
    end
  // a grant is never preempted; a pending refresh waits for the return to idle
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: state_nxt = bus.O_sdrc_init_done ? IDLE : INIT;
      IDLE: state_nxt = pending ? REFRESH :
                        (bus.p0_req && bus.p1_req) ? (last_grant ? GRANT0 : GRANT1) :
                        bus.p0_req ? GRANT0 : bus.p1_req ? GRANT1 : IDLE;
      GRANT0: state_nxt = bus.p0_req ? GRANT0 : IDLE;
      GRANT1: state_nxt = bus.p1_req ? GRANT1 : IDLE;
      REFRESH: state_nxt = REFRESH_WAIT;
      REFRESH_WAIT: state_nxt = bus.O_sdrc_cmd_ack ? IDLE : REFRESH_WAIT;
      default: state_nxt = INIT;
    endcase
  end
  assign bus.I_sdrc_cmd_en = g0 ? bus.p0_sdrc_cmd_en : g1 ? bus.p1_sdrc_cmd_en : rf;
  assign bus.I_sdrc_cmd = g0 ? bus.p0_sdrc_cmd : g1 ? bus.p1_sdrc_cmd : rf ? CmdAutoRefresh : 3'b000;
  assign bus.I_sdrc_precharge_ctrl = g0 ? bus.p0_sdrc_precharge_ctrl : g1 ? bus.p1_sdrc_precharge_ctrl : 1'b0;
  assign bus.I_sdrc_addr = g0 ? bus.p0_sdrc_addr : g1 ? bus.p1_sdrc_addr : '0;
  assign bus.I_sdrc_dqm = g0 ? bus.p0_sdrc_dqm : g1 ? bus.p1_sdrc_dqm : '0;
  assign bus.I_sdrc_data = g0 ? bus.p0_sdrc_data : g1 ? bus.p1_sdrc_data : '0;
  assign bus.I_sdrc_data_len = g0 ? bus.p0_sdrc_data_len : g1 ? bus.p1_sdrc_data_len : '0;
  assign bus.I_sdram_power_down = 1'b0;
  assign bus.I_sdram_selfrefresh = 1'b0;
  assign bus.p0_sdrc_rdata = bus.O_sdrc_data;
  assign bus.p1_sdrc_rdata = bus.O_sdrc_data;
  assign bus.p0_sdrc_cmd_ack = g0 & bus.O_sdrc_cmd_ack;
  assign bus.p1_sdrc_cmd_ack = g1 & bus.O_sdrc_cmd_ack;
  assign bus.p0_sdrc_init_done = bus.O_sdrc_init_done;
  assign bus.p1_sdrc_init_done = bus.O_sdrc_init_done;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed vector table plus hand-written grant, burst, refresh and reset sequences
module tb_sdram_arbiter;
  localparam logic [2:0] CMD_AR = 3'b001, CMD0 = 3'b010, CMD1 = 3'b100, CMD_RD = 3'b101;
  localparam logic [20:0] ADDR0 = 21'h0A5A5, ADDR1 = 21'h12345;
  typedef struct {
    logic r0, r1, en0, ack, g0, g1, en;
    logic [1:0] src;
    logic a0, a1;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  vec_t vec [16];
  always #5 clk = ~clk;
  sdram_arbiter_if bus ();
  sdram_arbiter_if bus_r ();
  sdram_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  sdram_arbiter #(.RefreshIntervalCycles(16)) dut_r (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {bus.p0_req, bus.p0_sdrc_cmd_en, bus.p0_sdrc_precharge_ctrl, bus.p1_req, bus.p1_sdrc_cmd_en} = '0;
    {bus.p1_sdrc_precharge_ctrl, bus.O_sdrc_cmd_ack, bus.O_sdrc_init_done} = '0;
    {bus.p0_sdrc_cmd, bus.p0_sdrc_addr, bus.p0_sdrc_dqm, bus.p0_sdrc_data, bus.p0_sdrc_data_len} = '0;
    {bus.p1_sdrc_cmd, bus.p1_sdrc_addr, bus.p1_sdrc_dqm, bus.p1_sdrc_data, bus.p1_sdrc_data_len} = '0;
    bus.O_sdrc_data = '0;
    {bus_r.p0_req, bus_r.p0_sdrc_cmd_en, bus_r.p0_sdrc_precharge_ctrl, bus_r.p1_req, bus_r.p1_sdrc_cmd_en} = '0;
    {bus_r.p1_sdrc_precharge_ctrl, bus_r.O_sdrc_cmd_ack, bus_r.O_sdrc_init_done} = '0;
    {bus_r.p0_sdrc_cmd, bus_r.p0_sdrc_addr, bus_r.p0_sdrc_dqm, bus_r.p0_sdrc_data, bus_r.p0_sdrc_data_len} = '0;
    {bus_r.p1_sdrc_cmd, bus_r.p1_sdrc_addr, bus_r.p1_sdrc_dqm, bus_r.p1_sdrc_data, bus_r.p1_sdrc_data_len} = '0;
    bus_r.O_sdrc_data = '0;
  endtask

  // leaves rst_n released 1ns after an edge, so the next edge is the first after reset
  task automatic do_reset(input logic init);
    rst_n = 1'b0;
    clear_inputs();
    bus.O_sdrc_init_done = init;
    bus_r.O_sdrc_init_done = init;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_refresh(input string tag, input int ack_delay, input int n, input int e0, input int e1, input int e2);
    int pulses[$];
    int exp[3];
    int last;
    exp = '{e0, e1, e2};
    last = -100;
    do_reset(1'b1);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (bus_r.I_sdrc_cmd_en) begin
        chk({tag, " cmd"}, 32'(bus_r.I_sdrc_cmd), 32'(CMD_AR));
        chk({tag, " addr"}, 32'(bus_r.I_sdrc_addr), 32'd0);
        chk({tag, " gnt"}, 32'({bus_r.p0_gnt, bus_r.p1_gnt}), 32'd0);
        pulses.push_back(c);
        last = c;
      end
      bus_r.O_sdrc_cmd_ack = c == last + ack_delay;
    end
    chk({tag, " pulse count"}, 32'(pulses.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < pulses.size()) chk($sformatf("%s pulse %0d cycle", tag, i), 32'(pulses[i]), 32'(exp[i]));
  endtask

  initial begin
    int words, hit;
    logic [2:0] ec;
    logic [20:0] ea;
    vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
    vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vec[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

    clear_inputs();
    bus.p0_req = 1'b1;
    bus.p0_sdrc_cmd_en = 1'b1;
    bus.p0_sdrc_addr = ADDR0;
    bus.O_sdrc_init_done = 1'b1;
    @(posedge clk);
    #1;
    chk("reset gnt", 32'({bus.p0_gnt, bus.p1_gnt}), 32'd0);
    chk("reset cmd_en", 32'(bus.I_sdrc_cmd_en), 32'd0);
    chk("reset addr", 32'(bus.I_sdrc_addr), 32'd0);
    chk("reset cmd", 32'(bus.I_sdrc_cmd), 32'd0);
    chk("power_down", 32'(bus.I_sdram_power_down), 32'd0);
    chk("selfrefresh", 32'(bus.I_sdram_selfrefresh), 32'd0);

    do_reset(1'b1);
    bus.p0_sdrc_cmd = CMD0;
    bus.p0_sdrc_addr = ADDR0;
    bus.p1_sdrc_cmd = CMD1;
    bus.p1_sdrc_addr = ADDR1;
    bus.p1_sdrc_cmd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.p0_req = vec[i].r0;
      bus.p1_req = vec[i].r1;
      bus.p0_sdrc_cmd_en = vec[i].en0;
      bus.O_sdrc_cmd_ack = vec[i].ack;
      @(posedge clk);
      #1;
      ec = vec[i].src == 2'd1 ? CMD0 : vec[i].src == 2'd2 ? CMD1 : 3'b000;
      ea = vec[i].src == 2'd1 ? ADDR0 : vec[i].src == 2'd2 ? ADDR1 : 21'd0;
      chk($sformatf("v%0d gnt0", i), 32'(bus.p0_gnt), 32'(vec[i].g0));
      chk($sformatf("v%0d gnt1", i), 32'(bus.p1_gnt), 32'(vec[i].g1));
      chk($sformatf("v%0d cmd_en", i), 32'(bus.I_sdrc_cmd_en), 32'(vec[i].en));
      chk($sformatf("v%0d cmd", i), 32'(bus.I_sdrc_cmd), 32'(ec));
      chk($sformatf("v%0d addr", i), 32'(bus.I_sdrc_addr), 32'(ea));
      chk($sformatf("v%0d ack0", i), 32'(bus.p0_sdrc_cmd_ack), 32'(vec[i].a0));
      chk($sformatf("v%0d ack1", i), 32'(bus.p1_sdrc_cmd_ack), 32'(vec[i].a1));
    end

    do_reset(1'b1);
    bus.p0_req = 1'b1;
    bus.p0_sdrc_cmd_en = 1'b1;
    bus.p0_sdrc_cmd = CMD_RD;
    bus.p0_sdrc_addr = ADDR0;
    bus.p0_sdrc_dqm = 4'hA;
    bus.p0_sdrc_data = 32'hCAFE_0001;
    bus.p0_sdrc_data_len = 8'd7;
    bus.p0_sdrc_precharge_ctrl = 1'b1;
    @(posedge clk);
    #1;
    chk("burst idle gnt0", 32'(bus.p0_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("burst gnt0", 32'(bus.p0_gnt), 32'd1);
    chk("burst cmd_en", 32'(bus.I_sdrc_cmd_en), 32'd1);
    chk("burst cmd", 32'(bus.I_sdrc_cmd), 32'(CMD_RD));
    chk("burst len", 32'(bus.I_sdrc_data_len), 32'd7);
    chk("burst dqm", 32'(bus.I_sdrc_dqm), 32'hA);
    chk("burst wdata", bus.I_sdrc_data, 32'hCAFE_0001);
    chk("burst precharge", 32'(bus.I_sdrc_precharge_ctrl), 32'd1);
    bus.p0_sdrc_cmd_en = 1'b0;
    bus.O_sdrc_cmd_ack = 1'b1;
    #1;
    chk("burst ack0", 32'(bus.p0_sdrc_cmd_ack), 32'd1);
    chk("burst ack1", 32'(bus.p1_sdrc_cmd_ack), 32'd0);
    @(posedge clk);
    #1;
    bus.O_sdrc_cmd_ack = 1'b0;
    words = 0;
    for (int k = 0; k < 8; k++) begin
      bus.O_sdrc_data = 32'hD000_0000 + 32'(k);
      #1;
      if (bus.p0_gnt && bus.p0_sdrc_rdata == 32'hD000_0000 + 32'(k)) words++;
      chk($sformatf("burst p1 rdata %0d", k), bus.p1_sdrc_rdata, 32'hD000_0000 + 32'(k));
      chk($sformatf("burst p1 ack %0d", k), 32'(bus.p1_sdrc_cmd_ack), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("burst words", 32'(words), 32'd8);
    bus.p0_req = 1'b0;
    @(posedge clk);
    #1;
    chk("burst release gnt0", 32'(bus.p0_gnt), 32'd0);

    do_reset(1'b1);
    bus.p0_req = 1'b1;
    bus.p0_sdrc_cmd_en = 1'b1;
    bus.p0_sdrc_addr = ADDR0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset pre gnt0", 32'(bus.p0_gnt), 32'd1);
    chk("midreset pre cmd_en", 32'(bus.I_sdrc_cmd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset gnt0", 32'(bus.p0_gnt), 32'd0);
    chk("midreset cmd_en", 32'(bus.I_sdrc_cmd_en), 32'd0);
    chk("midreset addr", 32'(bus.I_sdrc_addr), 32'd0);
    bus.O_sdrc_init_done = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("init wait gnt0 %0d", k), 32'(bus.p0_gnt), 32'd0);
    end
    chk("init_done0 low", 32'(bus.p0_sdrc_init_done), 32'd0);
    bus.O_sdrc_init_done = 1'b1;
    #1;
    chk("init_done0 high", 32'(bus.p0_sdrc_init_done), 32'd1);
    chk("init_done1 high", 32'(bus.p1_sdrc_init_done), 32'd1);
    @(posedge clk);
    #1;
    chk("post init idle gnt0", 32'(bus.p0_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("post init gnt0", 32'(bus.p0_gnt), 32'd1);

    run_refresh("refresh", 1, 3, 18, 34, 50);
    run_refresh("absorb", 17, 2, 18, 50, 0);

    do_reset(1'b1);
    bus_r.p1_req = 1'b1;
    hit = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c >= 2 && c <= 25 && (bus_r.I_sdrc_cmd_en || !bus_r.p1_gnt)) hit++;
      if (c == 26) chk("hold idle cmd_en", 32'(bus_r.I_sdrc_cmd_en), 32'd0);
      if (c == 27) begin
        chk("hold refresh cmd_en", 32'(bus_r.I_sdrc_cmd_en), 32'd1);
        chk("hold refresh cmd", 32'(bus_r.I_sdrc_cmd), 32'(CMD_AR));
        chk("hold refresh gnt0", 32'(bus_r.p0_gnt), 32'd0);
      end
      if (c == 29) chk("hold idle gnt0", 32'(bus_r.p0_gnt), 32'd0);
      if (c == 30) chk("hold late gnt0", 32'(bus_r.p0_gnt), 32'd1);
      bus_r.p0_req = c >= 4;
      bus_r.p1_req = c < 25;
      bus_r.O_sdrc_cmd_ack = c == 28;
    end
    chk("hold grant1 no refresh", 32'(hit), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
